// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Single-outstanding AXI4-Lite master. A command (read or write) is taken
//   from the cmd_* port when the block is idle, run on the M_AXI_* channels,
//   and completed with a one-cycle rsp_valid pulse carrying the response.
//   Each channel wait is bounded by TIMEOUT_CYCLES (0 = unbounded); an abort
//   completes with SLVERR and rsp_timeout set.
//
// Ports
//   S_AXI_ACLK, Local_Reset           clock, async active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_write/addr/wdata/wstrb        command payload
//   rsp_valid/rdata/resp/timeout      completion (rdata/resp/timeout held)
//   M_AXI_*                           AXI4-Lite master channels
module axi_lite_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        Local_Reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t                      r_state;
  logic                        r_cmd_ready;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic                        r_awvalid;
  logic                        r_wvalid;
  logic                        r_aw_done;
  logic                        r_w_done;
  logic                        r_bready;
  logic                        r_arvalid;
  logic                        r_rready;
  logic                        r_rsp_valid;
  logic [AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]                  r_rsp_resp;
  logic                        r_rsp_timeout;
  logic [WAIT_W-1:0]           r_wait;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_done;
  logic              w_w_done;
  logic              w_timeout;
  logic [WAIT_W-1:0] w_wait_inc;

  assign w_aw_hs    = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs     = r_wvalid & M_AXI_WREADY;
  // Handshakes on AW and W may land in any order; remember earlier ones.
  assign w_aw_done  = r_aw_done | w_aw_hs;
  assign w_w_done   = r_w_done | w_w_hs;
  assign w_timeout  = TO_EN && (r_wait == WAIT_LAST);
  assign w_wait_inc = (r_wait == '1) ? r_wait : r_wait + 1'b1;

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_rsp_timeout <= 1'b0;
      r_wait        <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wait <= '0;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // A handshake completing in the final allowed cycle wins over abort.
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_wait   <= '0;
            r_state  <= WR_RESP;
          end else if (w_timeout) begin
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_rsp_resp    <= 2'b10;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_wait        <= '0;
            r_state       <= DONE;
          end else begin
            r_wait <= w_wait_inc;
          end
        end

        WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready      <= 1'b0;
            r_rsp_resp    <= M_AXI_BRESP;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_wait        <= '0;
            r_state       <= DONE;
          end else if (w_timeout) begin
            r_bready      <= 1'b0;
            r_rsp_resp    <= 2'b10;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_wait        <= '0;
            r_state       <= DONE;
          end else begin
            r_wait <= w_wait_inc;
          end
        end

        RD_REQ: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_wait    <= '0;
            r_state   <= RD_RESP;
          end else if (w_timeout) begin
            r_arvalid     <= 1'b0;
            r_rsp_resp    <= 2'b10;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_wait        <= '0;
            r_state       <= DONE;
          end else begin
            r_wait <= w_wait_inc;
          end
        end

        RD_RESP: begin
          if (M_AXI_RVALID) begin
            r_rready      <= 1'b0;
            r_rsp_rdata   <= M_AXI_RDATA;
            r_rsp_resp    <= M_AXI_RRESP;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_wait        <= '0;
            r_state       <= DONE;
          end else if (w_timeout) begin
            r_rready      <= 1'b0;
            r_rsp_resp    <= 2'b10;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_wait        <= '0;
            r_state       <= DONE;
          end else begin
            r_wait <= w_wait_inc;
          end
        end

        DONE: begin
          r_cmd_ready <= 1'b1;
          r_wait      <= '0;
          r_state     <= IDLE;
        end

        default: begin
          r_cmd_ready <= 1'b0;
          r_wait      <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
//   Directed bench for axi_lite_master (TIMEOUT_CYCLES = 16) with a small
//   configurable AXI4-Lite slave. Latency is counted with the acceptance
//   cycle as cycle 1 and the rsp_valid cycle as cycle N.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        Local_Reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_lite_master #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .S_AXI_ACLK(clk),       .Local_Reset(Local_Reset),
    .cmd_valid(cmd_valid),  .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),  .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),  .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),  .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr),  .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid),.M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),    .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid),  .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),  .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),  .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),.M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp),    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  logic [149:0] all_out;
  assign all_out = {cmd_ready, awvalid, wvalid, bready, arvalid, rready,
                    rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, awaddr,
                    araddr, wdata, wstrb, awprot, arprot};

  // Slave configuration: *_cyc = cycles VALID/READY is held before the slave
  // responds (1 = same cycle, 0 = never).
  int          aw_cyc = 1, w_cyc = 1, ar_cyc = 1, b_cyc = 1, r_cyc = 1;
  logic [1:0]  bresp_cfg = '0, rresp_cfg = '0;
  logic [31:0] rdata_cfg = '0;

  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, b_hi = 0, rsp_cnt = 0, busy_rdy = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;

  // Slave responses and activity monitor, evaluated away from the clock edge.
  always @(negedge clk) begin
    if (awvalid) begin
      aw_n++; aw_hi++; awready = (aw_cyc != 0) && (aw_n >= aw_cyc);
    end else begin
      aw_n = 0; awready = 1'b0;
    end
    if (wvalid) begin
      w_n++; w_hi++; wready = (w_cyc != 0) && (w_n >= w_cyc);
    end else begin
      w_n = 0; wready = 1'b0;
    end
    if (arvalid) begin
      ar_n++; ar_hi++; arready = (ar_cyc != 0) && (ar_n >= ar_cyc);
    end else begin
      ar_n = 0; arready = 1'b0;
    end
    if (bready) begin
      b_n++; b_hi++; bvalid = (b_cyc != 0) && (b_n >= b_cyc); bresp = bresp_cfg;
    end else begin
      b_n = 0; bvalid = 1'b0;
    end
    if (rready) begin
      r_n++; rvalid = (r_cyc != 0) && (r_n >= r_cyc);
      rdata = rdata_cfg; rresp = rresp_cfg;
    end else begin
      r_n = 0; rvalid = 1'b0;
    end
    if (awvalid && awready) cap_awaddr = awaddr;
    if (wvalid && wready) begin cap_wdata = wdata; cap_wstrb = wstrb; end
    if (arvalid && arready) cap_araddr = araddr;
    if (rsp_valid) rsp_cnt++;
    if (cmd_ready && (awvalid || wvalid || bready || arvalid || rready || rsp_valid))
      busy_rdy++;
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and return at the negedge of the rsp_valid cycle.
  task automatic run_cmd(input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         output int lat);
    int n;
    bit got;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++;
      if (rsp_valid) got = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n;
    int s_aw, s_w, s_ar, s_b, s_rsp, s_busy;

    // Reset
    repeat (3) @(negedge clk);
    chk("reset_outputs_low", all_out, '0);
    Local_Reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", cmd_ready, 1);
    s_busy = busy_rdy;

    // Minimum-latency write
    @(negedge clk);
    s_rsp = rsp_cnt;
    run_cmd(1'b1, 32'h10, 32'h12345678, 4'h3, lat);
    chk("wr_min_latency", lat, 4);
    chk("wr_min_resp", rsp_resp, 2'b00);
    chk("wr_min_timeout", rsp_timeout, 0);
    @(negedge clk);
    chk("wr_min_awaddr", cap_awaddr, 32'h10);
    chk("wr_min_wdata", cap_wdata, 32'h12345678);
    chk("wr_min_wstrb", cap_wstrb, 4'h3);
    chk("wr_min_pulses", rsp_cnt - s_rsp, 1);

    // Write with AWREADY delayed: AWVALID 3 cycles, WVALID 1 cycle
    aw_cyc = 3;
    s_aw = aw_hi; s_w = w_hi; s_b = b_hi; s_rsp = rsp_cnt;
    run_cmd(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, lat);
    chk("wr_dly_latency", lat, 6);
    chk("wr_dly_resp", rsp_resp, 2'b00);
    @(negedge clk);
    chk("wr_dly_awvalid_cycles", aw_hi - s_aw, 3);
    chk("wr_dly_wvalid_cycles", w_hi - s_w, 1);
    chk("wr_dly_bready_cycles", b_hi - s_b, 1);
    chk("wr_dly_pulses", rsp_cnt - s_rsp, 1);
    chk("wr_dly_awaddr", cap_awaddr, 32'h8);
    chk("wr_dly_wdata", cap_wdata, 32'hDEADBEEF);
    aw_cyc = 1;

    // Minimum-latency read
    rdata_cfg = 32'hA5A55A5A;
    run_cmd(1'b0, 32'h40, 32'h0, 4'h0, lat);
    chk("rd_min_latency", lat, 4);
    chk("rd_min_rdata", rsp_rdata, 32'hA5A55A5A);
    @(negedge clk);
    chk("rd_min_araddr", cap_araddr, 32'h40);

    // Read with RVALID two cycles late
    r_cyc = 3; rdata_cfg = 32'h2;
    s_rsp = rsp_cnt;
    run_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat);
    chk("rd_dly_latency", lat, 6);
    chk("rd_dly_rdata", rsp_rdata, 32'h2);
    chk("rd_dly_resp", rsp_resp, 2'b00);
    @(negedge clk);
    chk("rd_dly_pulses", rsp_cnt - s_rsp, 1);
    chk("rd_dly_araddr", cap_araddr, 32'h4);
    r_cyc = 1;

    // Back-to-back: read presented during the rsp_valid cycle of a write
    run_cmd(1'b1, 32'h14, 32'h0BADF00D, 4'hF, lat);
    rdata_cfg = 32'h77;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    chk("b2b_ready_low_in_done", cmd_ready, 0);
    @(posedge clk); #1;
    chk("b2b_not_accepted_in_done", arvalid, 0);
    @(negedge clk);
    chk("b2b_ready_in_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_accepted_in_idle", arvalid, 1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("b2b_rsp_seen", rsp_valid, 1);
    chk("b2b_rdata", rsp_rdata, 32'h77);
    @(negedge clk);
    chk("b2b_araddr", cap_araddr, 32'h20);
    chk("ready_low_while_busy", busy_rdy - s_busy, 0);

    // Timeout: ARREADY never asserted
    ar_cyc = 0;
    s_ar = ar_hi; s_rsp = rsp_cnt;
    run_cmd(1'b0, 32'h30, 32'h0, 4'h0, lat);
    chk("to_latency", lat, 18);
    chk("to_resp", rsp_resp, 2'b10);
    chk("to_flag", rsp_timeout, 1);
    chk("to_rdata_held", rsp_rdata, 32'h77);
    @(negedge clk);
    chk("to_arvalid_cycles", ar_hi - s_ar, 16);
    chk("to_pulses", rsp_cnt - s_rsp, 1);
    chk("to_arvalid_dropped", arvalid, 0);
    ar_cyc = 1;
    rdata_cfg = 32'h55;
    run_cmd(1'b0, 32'h34, 32'h0, 4'h0, lat);
    chk("to_clear_flag", rsp_timeout, 0);
    chk("to_clear_resp", rsp_resp, 2'b00);
    chk("to_clear_rdata", rsp_rdata, 32'h55);

    // Slave error on write
    bresp_cfg = 2'b10;
    run_cmd(1'b1, 32'hC, 32'hCAFE0001, 4'hF, lat);
    chk("slverr_resp", rsp_resp, 2'b10);
    chk("slverr_timeout", rsp_timeout, 0);
    chk("slverr_rdata_held", rsp_rdata, 32'h55);
    bresp_cfg = 2'b00;

    // Reset while waiting for BVALID
    b_cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50;
    cmd_wdata = 32'h11; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!bready && n < 10) begin @(negedge clk); n++; end
    chk("midwr_in_wr_resp", bready, 1);
    #2 Local_Reset = 1'b1;
    #1;
    chk("midwr_async_outputs_low", all_out, '0);
    s_rsp = rsp_cnt;
    repeat (2) @(negedge clk);
    Local_Reset = 1'b0;
    b_cyc = 1;
    @(posedge clk); #1;
    chk("midwr_ready_after_release", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk("midwr_no_rsp", rsp_cnt - s_rsp, 0);

    // Normal operation after reset recovery
    run_cmd(1'b1, 32'h18, 32'h99, 4'h1, lat);
    chk("recover_latency", lat, 4);
    chk("recover_resp", rsp_resp, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 32, sets the width of the address buses.
REQ-002 Parameter AXI_DATA_WIDTH, default 32, sets the data bus width; legal values are 32 or 64.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, is the maximum number of cycles spent waiting on any single AXI channel before abort; 0 disables the timeout.
REQ-004 S_AXI_ACLK  in  1  clock; reset Local_Reset, asynchronous, active-high; clock S_AXI_ACLK.
REQ-005 Local_Reset  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  AXI_ADDR_WIDTH  byte address.
REQ-010 cmd_wdata  in  AXI_DATA_WIDTH  write data.
REQ-011 cmd_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  AXI_DATA_WIDTH  read data.
REQ-014 rsp_resp  out  2  BRESP or RRESP of the completed transaction.
REQ-015 rsp_timeout  out  1  completion was an abort caused by timeout.
REQ-016 M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  per AXI4-Lite master direction and width.
REQ-017 M_AXI_AWPROT and M_AXI_ARPROT  out  3  tied to 3'b000.

Function
REQ-018 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; the state register is clocked on S_AXI_ACLK.
REQ-019 cmd_ready is 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready, and cmd_addr, cmd_wdata, cmd_wstrb and cmd_write are registered at acceptance.
REQ-020 Transitions on accept: IDLE->WR_REQ when cmd_write = 1, IDLE->RD_REQ when cmd_write = 0.
REQ-021 WR_REQ: AWVALID and WVALID are asserted in the cycle after acceptance; each is deasserted independently in the cycle after its own handshake (VALID&&READY).
REQ-022 WR_REQ->WR_RESP once both the AW and W handshakes have completed, whether in the same cycle or in either order.
REQ-023 WR_RESP: BREADY = 1; on BVALID, BRESP is captured into rsp_resp and the FSM moves to DONE.
REQ-024 RD_REQ: ARVALID = 1 until the AR handshake, then the FSM moves to RD_RESP.
REQ-025 RD_RESP: RREADY = 1; on RVALID, RDATA and RRESP are captured and the FSM moves to DONE.
REQ-026 DONE: rsp_valid = 1 for exactly one cycle, then DONE->IDLE unconditionally.
REQ-027 Once asserted, a VALID is never deasserted before its handshake, and address, data and strobes are stable while VALID is high.
REQ-028 All AXI outputs and rsp_* outputs are registered; there is no combinational path from any input to any output.
REQ-029 rsp_rdata, rsp_resp and rsp_timeout hold their values until the next DONE; rsp_rdata is unchanged by writes.
REQ-030 Minimum latency with slave READY/VALID always high: write = 4 cycles and read = 4 cycles from acceptance to the rsp_valid pulse.
REQ-031 Timeout: a wait counter is cleared on every state entry and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP; when it reaches TIMEOUT_CYCLES-1:
 - all VALID/READY outputs drop in the next cycle;
 - rsp_resp = 2'b10 (SLVERR) and rsp_timeout = 1;
 - the FSM goes to DONE.
REQ-032 rsp_timeout is cleared at the next normal completion.
REQ-033 The wait counter saturates; there is no wrap-around.
REQ-034 cmd_valid asserted outside IDLE is ignored; the command is not latched.

Reset
REQ-035 When Local_Reset is asserted at any time, including mid-transaction, the block immediately enters IDLE and all outputs go low (cmd_ready = 0, all AXI VALID/READY = 0, rsp_* = 0).
REQ-036 In the first cycle after reset deassertion the block is in IDLE and cmd_ready = 1.
REQ-037 A transaction in flight at reset is dropped; no rsp_valid is generated for it.

Verification
REQ-038 Write: addr 0x8, data 0xDEADBEEF, strb 0xF, slave AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops first, AWVALID holds 3 cycles, then BREADY is asserted; rsp_valid pulses once with rsp_resp = 00.
REQ-039 Read: addr 0x4, slave returns RDATA = 0x00000002, RRESP = 00 after 2 cycles -> rsp_rdata = 0x2, rsp_valid pulses once, total latency 6 cycles.
REQ-040 Back-to-back commands: a read is presented on the rsp_valid cycle -> it is not accepted until IDLE; cmd_ready = 0 for the entire transaction.
REQ-041 Timeout: TIMEOUT_CYCLES = 16, slave never asserts ARREADY -> ARVALID drops after 16 cycles; rsp_resp = 10 and rsp_timeout = 1; a following normal read clears rsp_timeout.
REQ-042 Reset mid-write: Local_Reset asserted while in WR_RESP -> all outputs go to 0 asynchronously, no rsp_valid is generated, and cmd_ready = 1 in the first cycle after release.
REQ-043 Slave error: BRESP = 2'b10 on a write to addr 0xC -> rsp_resp = 10 and rsp_timeout = 0.
